// File: rtl/requant_cfu_pkg.sv
// requant_cfu_pkg: opcodes, int32 limits and FSM states shared by the requantizer.
package requant_cfu_pkg;
  localparam logic [2:0] FN_SET_MULT     = 3'd0;
  localparam logic [2:0] FN_SET_OUT      = 3'd1;
  localparam logic [2:0] FN_REQUANT      = 3'd2;
  localparam logic [2:0] FN_REQUANT_PACK = 3'd3;
  localparam logic signed [31:0] INT32_MIN = 32'sh8000_0000;
  localparam logic signed [31:0] INT32_MAX = 32'sh7FFF_FFFF;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
endpackage

// File: rtl/requant_cfu_if.sv
// requant_cfu_if: CPU custom-instruction command/response bus.
interface requant_cfu_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_payload_function_id;
  logic [31:0] cmd_payload_inputs_0;
  logic [31:0] cmd_payload_inputs_1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_payload_outputs_0;
  modport master(output cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1, rsp_ready,
                 input cmd_ready, rsp_valid, rsp_payload_outputs_0);
  modport slave(input cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1, rsp_ready,
                output cmd_ready, rsp_valid, rsp_payload_outputs_0);
endinterface

// File: rtl/requant_cfu_srdhm_mul.sv
// srdhm_mul: pipelined saturating rounding doubling high multiply, MUL_STAGES+1 cycles input to output.
module srdhm_mul import requant_cfu_pkg::*; #(
  parameter int MUL_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_valid,
  input  logic signed [31:0] i_a,
  input  logic signed [31:0] i_b,
  output logic               o_valid,
  output logic signed [31:0] o_h
);
  logic signed [63:0] r_p [MUL_STAGES];
  logic [MUL_STAGES-1:0] r_sat;
  logic [MUL_STAGES-1:0] r_v;
  logic signed [63:0] w_a, w_b, w_s;
  assign w_a = {{32{i_a[31]}}, i_a};
  assign w_b = {{32{i_b[31]}}, i_b};
  assign w_s = r_p[MUL_STAGES-1] + ((r_p[MUL_STAGES-1] >= 0) ? 64'sd1073741824 : -64'sd1073741823);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_v     <= '0;
      o_valid <= 1'b0;
    end else begin
      r_v[0] <= i_valid;
      for (int i = 1; i < MUL_STAGES; i++) r_v[i] <= r_v[i-1];
      o_valid <= r_v[MUL_STAGES-1];
    end
  // Division by 2^31 truncates toward zero, so negative sums are biased before the arithmetic shift.
  always_ff @(posedge clk) begin
    r_p[0]   <= w_a * w_b;
    r_sat[0] <= (i_a == INT32_MIN) && (i_b == INT32_MIN);
    for (int i = 1; i < MUL_STAGES; i++) begin
      r_p[i]   <= r_p[i-1];
      r_sat[i] <= r_sat[i-1];
    end
    o_h <= r_sat[MUL_STAGES-1] ? INT32_MAX : 32'((w_s < 0) ? (w_s + 64'sh7FFF_FFFF) >>> 31 : w_s >>> 31);
  end
endmodule

// File: rtl/requant_cfu.sv
// requant_cfu: TFLite int8 requantization custom-instruction unit.
// Holds the FSM, config registers, rounding shift, offset/clamp and the byte-pack register.
module requant_cfu import requant_cfu_pkg::*; #(
  parameter int MUL_STAGES = 2
) (
  input logic         clk,
  input logic         reset_n,
  requant_cfu_if.slave bus
);
  state_t r_state, w_next;
  logic [2:0] r_cnt;
  logic signed [31:0] r_mult, r_x;
  logic [4:0] r_shift;
  logic [8:0] r_off;
  logic signed [7:0] r_min, r_max;
  logic [31:0] r_pack, r_out;
  logic r_xv, r_op_pack;
  logic [2:0] w_fn;
  logic w_accept, w_is_rq, w_hv, w_unused;
  logic signed [31:0] w_h, w_d;
  logic [31:0] w_mask, w_rem, w_thr;
  logic signed [32:0] w_sum, w_lo, w_hi, w_c;
  logic [7:0] w_r;
  assign w_fn     = bus.cmd_payload_function_id[2:0];
  assign w_unused = ^bus.cmd_payload_function_id[9:3];
  assign w_accept = bus.cmd_valid && (r_state == IDLE);
  assign w_is_rq  = (w_fn == FN_REQUANT) || (w_fn == FN_REQUANT_PACK);
  assign bus.cmd_ready = (r_state == IDLE);
  assign bus.rsp_valid = (r_state == RESP);
  assign bus.rsp_payload_outputs_0 = r_out;
  srdhm_mul #(.MUL_STAGES(MUL_STAGES)) u_mul (
    .clk(clk), .reset_n(reset_n), .i_valid(r_xv), .i_a(r_x), .i_b(r_mult), .o_valid(w_hv), .o_h(w_h)
  );
  // Rounding divide by 2^shift, ties away from zero.
  assign w_mask = (32'd1 << r_shift) - 32'd1;
  assign w_rem  = w_h & w_mask;
  assign w_thr  = (w_mask >> 1) + {31'd0, w_h[31]};
  assign w_d    = (w_h >>> r_shift) + ((w_rem > w_thr) ? 32'sd1 : 32'sd0);
  assign w_sum  = {w_d[31], w_d} + {{24{r_off[8]}}, r_off};
  assign w_lo   = {{25{r_min[7]}}, r_min};
  assign w_hi   = {{25{r_max[7]}}, r_max};
  // Lower clamp first so an inverted range collapses onto act_max.
  assign w_c    = (w_sum < w_lo) ? w_lo : w_sum;
  assign w_r    = (w_c > w_hi) ? r_max : w_c[7:0];
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE && bus.cmd_valid) w_next = w_is_rq ? BUSY : RESP;
    else if (r_state == BUSY && r_cnt == 3'd0) w_next = RESP;
    else if (r_state == RESP && bus.rsp_ready) w_next = IDLE;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_mult    <= '0;
      r_shift   <= '0;
      r_off     <= '0;
      r_min     <= -8'sd128;
      r_max     <= 8'sd127;
      r_pack    <= '0;
      r_out     <= '0;
      r_x       <= '0;
      r_xv      <= 1'b0;
      r_op_pack <= 1'b0;
    end else begin
      r_state <= w_next;
      r_xv    <= w_accept && w_is_rq;
      if (r_state == BUSY) r_cnt <= r_cnt - 3'd1;
      if (w_accept) begin
        r_cnt     <= 3'(MUL_STAGES + 1);
        r_x       <= bus.cmd_payload_inputs_0 + bus.cmd_payload_inputs_1;
        r_op_pack <= (w_fn == FN_REQUANT_PACK);
        r_out     <= '0;
        if (w_fn == FN_SET_MULT) begin
          r_mult  <= bus.cmd_payload_inputs_0;
          r_shift <= (bus.cmd_payload_inputs_1[5:0] > 6'd31) ? 5'd31 : bus.cmd_payload_inputs_1[4:0];
        end
        if (w_fn == FN_SET_OUT) begin
          r_off <= bus.cmd_payload_inputs_0[8:0];
          r_min <= bus.cmd_payload_inputs_1[7:0];
          r_max <= bus.cmd_payload_inputs_1[15:8];
        end
      end
      if (w_hv) begin
        r_out <= r_op_pack ? {w_r, r_pack[31:8]} : {{24{w_r[7]}}, w_r};
        if (r_op_pack) r_pack <= {w_r, r_pack[31:8]};
      end
    end
endmodule

// File: tb/tb_requant_cfu.sv
// tb_requant_cfu: scoreboard bench for requant_cfu against an integer requantization model.
module tb_requant_cfu;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] sb_q[$];
  int m_mult, m_shift, m_off, m_min, m_max;
  logic [31:0] m_pack;
  requant_cfu_if bus();
  requant_cfu #(.MUL_STAGES(2)) dut(.clk(clk), .reset_n(reset_n), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    m_mult = 0; m_shift = 0; m_off = 0; m_min = -128; m_max = 127; m_pack = '0;
  endtask
  function automatic logic [31:0] model_r(input int x);
    longint p, s, h, a, q, d, r;
    p = longint'(x) * longint'(m_mult);
    if (x == int'(32'h8000_0000) && m_mult == int'(32'h8000_0000)) h = 2147483647;
    else begin
      s = p + ((p >= 0) ? (longint'(1) << 30) : 1 - (longint'(1) << 30));
      h = s / (longint'(1) << 31);
    end
    if (m_shift == 0) d = h;
    else begin
      a = (h < 0) ? -h : h;
      q = (a + (longint'(1) << (m_shift - 1))) >> m_shift;
      d = (h < 0) ? -q : q;
    end
    r = d + m_off;
    if (m_min > m_max) r = m_max;
    else begin
      if (r < m_min) r = m_min;
      if (r > m_max) r = m_max;
    end
    return 32'(r);
  endfunction
  task automatic send(input logic [9:0] fid, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] e, r;
    logic [2:0] fn;
    int lat, n;
    fn = fid[2:0];
    e = '0;
    if (fn == 3'd0) begin m_mult = int'(a); m_shift = (b[5:0] > 6'd31) ? 31 : int'(b[5:0]); end
    if (fn == 3'd1) begin m_off = int'($signed(a[8:0])); m_min = int'($signed(b[7:0])); m_max = int'($signed(b[15:8])); end
    if (fn == 3'd2 || fn == 3'd3) begin
      r = model_r(int'(a) + int'(b));
      e = r;
      if (fn == 3'd3) begin m_pack = {r[7:0], m_pack[31:8]}; e = m_pack; end
    end
    sb_q.push_back(e);
    lat = (fn == 3'd2 || fn == 3'd3) ? 5 : 1;
    @(negedge clk);
    n = 0;
    while (!bus.cmd_ready && n < 20) begin @(negedge clk); n++; end
    chk("cmd_ready", 32'(bus.cmd_ready), 32'd1);
    bus.rsp_ready = (hold == 0);
    bus.cmd_valid = 1'b1;
    bus.cmd_payload_function_id = fid;
    bus.cmd_payload_inputs_0 = a;
    bus.cmd_payload_inputs_1 = b;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.rsp_valid && n < 20);
    chk("latency", 32'(n), 32'(lat));
    chk("result", bus.rsp_payload_outputs_0, sb_q.pop_front());
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_payload", bus.rsp_payload_outputs_0, e);
      chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
      chk("hold_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    chk("retired", 32'(bus.rsp_valid), 32'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    int cnt;
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.cmd_payload_function_id = '0;
    bus.cmd_payload_inputs_0 = '0;
    bus.cmd_payload_inputs_1 = '0;
    model_reset();
    #12 chk("rst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_payload", bus.rsp_payload_outputs_0, 32'd0);
    @(negedge clk) reset_n = 1'b1;
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    send(10'd0, 32'h4000_0000, 32'd0, 0);
    send(10'd1, 32'h0000_0180, 32'h7F80, 0);
    send(10'd2, 32'd1000, 32'd0, 0);
    chk("t1_model", model_r(1000), 32'h0000_007F);
    send(10'd0, 32'h4000_0000, 32'd1, 0);
    send(10'd1, 32'd10, 32'h7F80, 0);
    send(10'd2, -32'sd300, 32'd100, 0);
    chk("t2_model", model_r(-200), 32'hFFFF_FFD8);
    send(10'd0, 32'h8000_0000, 32'd0, 0);
    send(10'd1, 32'd0, 32'h7F80, 0);
    send(10'd2, 32'h8000_0000, 32'd0, 0);
    send(10'd0, 32'h7FFF_FFFF, 32'd1, 0);
    send(10'd2, 32'd5, 32'd0, 0);
    send(10'd2, -32'sd5, 32'd0, 0);
    send(10'd0, 32'h7FFF_FFFF, 32'd0, 0);
    send(10'd2, 32'd5, 32'd0, 0);
    send(10'd0, 32'h7FFF_FFFF, 32'd40, 0);
    send(10'd2, 32'h7FFF_FFFF, 32'd0, 0);
    send(10'd1, 32'd0, 32'hFB0A, 0);
    send(10'd2, 32'd77, 32'd0, 0);
    send({7'h55, 3'd5}, 32'hDEAD_BEEF, 32'h1234_5678, 0);
    send({7'h2A, 3'd2}, 32'd1000, 32'd0, 0);
    send(10'd0, 32'h7FFF_FFFF, 32'd0, 0);
    send(10'd1, 32'd0, 32'h7F80, 0);
    send(10'd3, 32'd1, 32'd0, 0);
    send(10'd3, 32'd2, 32'd0, 0);
    send(10'd3, 32'd3, 32'd0, 0);
    send(10'd3, 32'd4, 32'd0, 5);
    chk("pack_model", m_pack, 32'h0403_0201);
    for (int i = 0; i < 8; i++) begin
      send(10'd0, $urandom, 32'($urandom_range(0, 40)), 0);
      send(10'd1, 32'($urandom_range(0, 511)), {16'd0, 8'($urandom_range(0, 127)), 8'($urandom_range(128, 255))}, 0);
      send(10'd2, 32'($urandom_range(0, 20000)) - 32'd10000, 32'($urandom_range(0, 100)), 0);
    end
    send(10'd0, 32'h4000_0000, 32'd2, 0);
    send(10'd1, 32'd5, 32'h7F80, 0);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_payload_function_id = 10'd2;
    bus.cmd_payload_inputs_0 = 32'd1000;
    bus.cmd_payload_inputs_1 = 32'd0;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1 chk("midrst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("midrst_payload", bus.rsp_payload_outputs_0, 32'd0);
    chk("midrst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    model_reset();
    @(negedge clk) reset_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) cnt++;
    end
    chk("no_stale_rsp", 32'(cnt), 32'd0);
    send(10'd2, 32'd1000, 32'd0, 0);
    send(10'd1, 32'd3, 32'h7F80, 0);
    send(10'd2, 32'd1000, 32'd0, 0);
    send(10'd3, 32'd1000, 32'd0, 0);
    chk("pack_after_rst", m_pack, 32'h0300_0000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
